// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the oversampling UART receiver and its FIFO.
package uart_rx_pkg;

    // Widest character the entry format can carry.
    localparam int unsigned MaxDataBits = 9;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2,
        StBreak
    } rx_state_e;

    typedef struct packed {
        logic                   frame_err;
        logic                   parity_err;
        logic [MaxDataBits-1:0] data;
    } rx_entry_t;

    // Pointer width for a power-of-two FIFO of the given depth.
    function automatic int unsigned fifo_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo_showahead.sv
// Single-clock show-ahead FIFO: head word is visible combinationally while non-empty.
module sync_fifo_showahead
    import uart_rx_pkg::*;
#(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 16,
    localparam int unsigned PtrW = fifo_ptr_w(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             drop_o,
    output logic [PtrW:0]    level_o
);

    localparam logic [PtrW:0] DepthL = (PtrW + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [PtrW:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == DepthL);
    assign empty_o = (level_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push_i & (~full_o | do_pop);
    assign drop_o  = push_i & ~do_push;
    assign level_o = level_q;
    // Empty FIFO presents zero rather than stale storage.
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    // Next-state for pointers and occupancy; pointers wrap naturally at Depth.
    always_comb begin
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (!do_push && do_pop) begin
            level_d = level_q - 1'b1;
        end
    end

    // Storage write port (no reset needed; reads are gated by empty).
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Pointer and level registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with runtime framing options feeding a show-ahead FIFO.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DIV_W-1:0]              divisor,
    input  logic [3:0]                    char_len,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          two_stop,
    input  logic                          rxd,
    output logic                          rd_valid,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_parity_err,
    output logic                          rd_frame_err,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic                          busy
);

    localparam int unsigned    SampW    = $clog2(OVERSAMPLE);
    localparam logic [SampW-1:0] HalfLast = SampW'(OVERSAMPLE / 2 - 1);
    localparam logic [SampW-1:0] FullLast = SampW'(OVERSAMPLE - 1);
    localparam logic [3:0]       MaxLen   = 4'(DATA_BITS);

    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic [DIV_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic                 tick, at_sample, start_fall;
    rx_state_e            state_q, state_d;
    logic [SampW-1:0]     samp_cnt_q, samp_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [3:0]           len_q, len_d;
    logic                 par_en_q, par_en_d, par_odd_q, par_odd_d, two_stop_q, two_stop_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_acc_q, par_acc_d, par_err_q, par_err_d, frm_err_q, frm_err_d;
    logic                 push_q, push_d;
    logic                 overflow_q, overflow_d;
    logic                 fifo_empty, fifo_full, fifo_drop;
    rx_entry_t            push_entry, head;

    assign tick       = (tick_cnt_q == divisor);
    assign start_fall = rx_prev_q & ~rx_sync_q;
    assign at_sample  = tick && (samp_cnt_q == ((state_q == StStart) ? HalfLast : FullLast));

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Receiver next-state: framing, bit assembly, error flags and push request.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        samp_cnt_d = samp_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        len_d      = len_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        two_stop_d = two_stop_q;
        data_d     = data_q;
        par_acc_d  = par_acc_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        push_d     = 1'b0;
        if (tick) begin
            samp_cnt_d = at_sample ? '0 : samp_cnt_q + 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (start_fall) begin
                    state_d    = StStart;
                    tick_cnt_d = '0;
                    samp_cnt_d = '0;
                    bit_cnt_d  = '0;
                    data_d     = '0;
                    par_acc_d  = 1'b0;
                    par_err_d  = 1'b0;
                    frm_err_d  = 1'b0;
                    // Frame configuration is frozen here for the whole character.
                    len_d      = (char_len >= 4'd5 && char_len <= MaxLen) ? char_len : MaxLen;
                    par_en_d   = parity_en;
                    par_odd_d  = parity_odd;
                    two_stop_d = two_stop;
                end
            end
            StStart: begin
                if (at_sample) begin
                    state_d = rx_sync_q ? StIdle : StData;
                end
            end
            StData: begin
                if (at_sample) begin
                    for (int i = 0; i < int'(DATA_BITS); i++) begin
                        if (bit_cnt_q == 4'(i)) begin
                            data_d[i] = rx_sync_q;
                        end
                    end
                    par_acc_d = par_acc_q ^ rx_sync_q;
                    if (bit_cnt_q == len_q - 4'd1) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? StParity : StStop1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            StParity: begin
                if (at_sample) begin
                    par_err_d = ((par_acc_q ^ rx_sync_q) != par_odd_q);
                    state_d   = StStop1;
                end
            end
            StStop1, StStop2: begin
                if (at_sample) begin
                    if (!rx_sync_q) begin
                        frm_err_d = 1'b1;
                    end
                    if (state_q == StStop1 && two_stop_q) begin
                        state_d = StStop2;
                    end else begin
                        push_d  = 1'b1;
                        // A low final stop bit means the line is held in break.
                        state_d = rx_sync_q ? StIdle : StBreak;
                    end
                end
            end
            StBreak: begin
                if (rx_sync_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Receiver state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            samp_cnt_q <= '0;
            bit_cnt_q  <= '0;
            len_q      <= MaxLen;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            data_q     <= '0;
            par_acc_q  <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            push_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            len_q      <= len_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            two_stop_q <= two_stop_d;
            data_q     <= data_d;
            par_acc_q  <= par_acc_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            push_q     <= push_d;
        end
    end

    assign push_entry = '{
        frame_err:  frm_err_q,
        parity_err: par_err_q,
        data:       MaxDataBits'(data_q)
    };

    sync_fifo_showahead #(
        .Width ($bits(rx_entry_t)),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push_q),
        .wdata_i (push_entry),
        .pop_i   (rd_ready),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop),
        .level_o (level)
    );

    // Sticky overflow; a new drop takes priority over a clear in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (fifo_drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    generate
        if (DATA_BITS < MaxDataBits) begin : g_unused_hi
            logic unused_data_hi;
            assign unused_data_hi = ^head.data[MaxDataBits-1:DATA_BITS] ^ fifo_full;
        end else begin : g_full_width
            logic unused_full;
            assign unused_full = fifo_full;
        end
    endgenerate

    assign rd_valid      = ~fifo_empty;
    assign rd_data       = head.data[DATA_BITS-1:0];
    assign rd_parity_err = head.parity_err;
    assign rd_frame_err  = head.frame_err;
    assign overflow      = overflow_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: divisor 0, 16x oversampling, one bit = 16 clocks.
module tb_uart_rx_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] divisor;
    logic [3:0]  char_len;
    logic        parity_en, parity_odd, two_stop;
    logic        rxd;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        rd_parity_err, rd_frame_err;
    logic        rd_ready;
    logic [4:0]  level;
    logic        overflow, clr_overflow, busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_rx_fifo dut (
        .clk           (clk),
        .reset         (reset),
        .divisor       (divisor),
        .char_len      (char_len),
        .parity_en     (parity_en),
        .parity_odd    (parity_odd),
        .two_stop      (two_stop),
        .rxd           (rxd),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_parity_err (rd_parity_err),
        .rd_frame_err  (rd_frame_err),
        .rd_ready      (rd_ready),
        .level         (level),
        .overflow      (overflow),
        .clr_overflow  (clr_overflow),
        .busy          (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        wait_clks(16);
    endtask

    task automatic send_frame(input logic [8:0] d, input int nbits, input logic pen,
                              input logic pbit, input int nstop);
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        repeat (nstop) drive_bit(1'b1);
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic set_8n1();
        char_len   = 4'd8;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        two_stop   = 1'b0;
    endtask

    initial begin
        logic saw_busy;
        reset        = 1'b1;
        divisor      = '0;
        rxd          = 1'b1;
        rd_ready     = 1'b0;
        clr_overflow = 1'b0;
        set_8n1();
        wait_clks(3);

        // Reset state
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);
        check("rst_perr", rd_parity_err, 0);
        check("rst_ferr", rd_frame_err, 0);
        check("rst_level", level, 0);
        check("rst_ovf", overflow, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        wait_clks(5);

        // 8N1 0xA5
        send_frame(9'h0A5, 8, 1'b0, 1'b0, 1);
        check("a5_valid", rd_valid, 1);
        check("a5_data", rd_data, 8'hA5);
        check("a5_perr", rd_parity_err, 0);
        check("a5_ferr", rd_frame_err, 0);
        check("a5_level", level, 1);
        pop_one();
        check("a5_pop_valid", rd_valid, 0);
        pop_one();
        check("empty_pop_level", level, 0);
        wait_clks(10);

        // 7E2: 0x55 with wrong parity (correct would be 0), then 0x2A correct (1)
        char_len  = 4'd7;
        parity_en = 1'b1;
        two_stop  = 1'b1;
        send_frame(9'h055, 7, 1'b1, 1'b1, 2);
        send_frame(9'h02A, 7, 1'b1, 1'b1, 2);
        check("7e2_level", level, 2);
        check("7e2_d0", rd_data, 8'h55);
        check("7e2_p0", rd_parity_err, 1);
        check("7e2_f0", rd_frame_err, 0);
        pop_one();
        check("7e2_d1", rd_data, 8'h2A);
        check("7e2_p1", rd_parity_err, 0);
        check("7e2_f1", rd_frame_err, 0);
        pop_one();
        check("7e2_empty", rd_valid, 0);
        set_8n1();
        wait_clks(10);

        // 0x00 with the stop bit held low for three bit-times
        for (int i = 0; i < 9; i++) drive_bit(1'b0);
        wait_clks(20);
        check("brk_busy", busy, 1);
        check("brk_level", level, 1);
        wait_clks(28);
        rxd = 1'b1;
        wait_clks(40);
        check("brk_idle", busy, 0);
        check("brk_one_entry", level, 1);
        check("brk_data", rd_data, 8'h00);
        check("brk_ferr", rd_frame_err, 1);
        check("brk_perr", rd_parity_err, 0);
        pop_one();
        send_frame(9'h05A, 8, 1'b0, 1'b0, 1);
        check("post_brk_level", level, 1);
        check("post_brk_data", rd_data, 8'h5A);
        check("post_brk_ferr", rd_frame_err, 0);
        pop_one();
        wait_clks(10);

        // 6-clock glitch on an idle line
        rxd = 1'b0;
        wait_clks(6);
        rxd = 1'b1;
        saw_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        check("glitch_busy_pulse", saw_busy, 1);
        check("glitch_idle", busy, 0);
        check("glitch_level", level, 0);
        wait_clks(10);

        // Fill past depth with no reads
        for (int i = 0; i < 17; i++) send_frame(9'(8'h10 + i), 8, 1'b0, 1'b0, 1);
        check("ovf_level", level, 16);
        check("ovf_flag", overflow, 1);
        check("ovf_head", rd_data, 8'h10);
        // Pop timed onto the push cycle of an 18th character
        fork
            send_frame(9'h021, 8, 1'b0, 1'b0, 1);
            begin
                wait_clks(155);
                pop_one();
            end
        join
        check("simul_level", level, 16);
        check("simul_head", rd_data, 8'h11);
        check("ovf_sticky", overflow, 1);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        check("ovf_clr", overflow, 0);
        wait_clks(10);

        // Reset in the middle of the data bits
        drive_bit(1'b0);
        drive_bit(1'b1);
        rxd = 1'b0;
        wait_clks(8);
        check("mid_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", rd_valid, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_data", rd_data, 0);
        check("mid_rst_ovf", overflow, 0);
        rxd = 1'b1;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(20);
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1);
        check("after_rst_level", level, 1);
        check("after_rst_data", rd_data, 8'h3C);
        check("after_rst_ferr", rd_frame_err, 0);
        check("after_rst_perr", rd_parity_err, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised successor to the fixed 8N1 UART receive path used by the Nios/HPS peripheral set.
- Oversampling asynchronous receiver with runtime baud divisor and configurable data width (5-9 bits).
- Optional even/odd parity, one or two stop bits, per-character error flags, buffered in a show-ahead FIFO with sticky overflow.
- Sits between a board/HPS-loaned RX pin and a memory-mapped CSR wrapper or streaming consumer.

Parameters:
- DATA_BITS, 8, maximum character width; legal range 5..9.
- FIFO_DEPTH, 16, receive FIFO entries; power of two, at least 2.
- OVERSAMPLE, 16, sample ticks per bit; even, at least 4.
- DIV_W, 16, width of the baud divisor input.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- divisor  in  DIV_W  sample tick every divisor+1 clocks.
- char_len  in  4  active data bits, 5..DATA_BITS; other values are treated as DATA_BITS.
- parity_en  in  1  expect a parity bit.
- parity_odd  in  1  1 = odd parity, 0 = even.
- two_stop  in  1  expect two stop bits.
- rxd  in  1  asynchronous serial input, idle high.
- rd_valid  out  1  FIFO non-empty.
- rd_data  out  DATA_BITS  head character, LSB-aligned, unused MSBs zero.
- rd_parity_err  out  1  head entry parity error.
- rd_frame_err  out  1  head entry framing error.
- rd_ready  in  1  pop the head entry when rd_valid is high.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a character was dropped.
- clr_overflow  in  1  clears overflow.
- busy  out  1  receiver FSM not in IDLE.

Behaviour:
- Reset values: rd_valid=0, rd_data=0, both error flags=0, level=0, overflow=0, busy=0. Synchroniser flops reset to 1. FSM goes to IDLE.
- rxd passes through a 2-FF synchroniser, so all timing below is relative to the synchronised signal.
- Tick counter runs 0..divisor and pulses tick when it equals divisor; divisor=0 gives a tick every clock. It free-runs but restarts at 0 on start detection.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK.
- IDLE -> START on a high-to-low transition of the synchronised line. Latch char_len, parity_en, parity_odd and two_stop here; configuration changes mid-frame have no effect until the next start.
- START: after OVERSAMPLE/2 ticks, sample the line.
  - High: glitch; return to IDLE, nothing pushed.
  - Low: enter DATA with the sample counter reset.
- DATA: sample every OVERSAMPLE ticks, LSB first, char_len bits. Then go to PARITY if parity_en, else STOP1.
- PARITY: parity_err = (XOR of data bits XOR parity bit) != parity_odd.
- STOP1 / STOP2: a low sample sets frame_err.
  - The entry is pushed in the cycle after the final stop-bit sample: STOP1 if two_stop=0, else STOP2.
  - If the final stop sample was low -> BREAK, otherwise -> IDLE.
- BREAK: wait for the synchronised line to go high, then IDLE. No new start is detected while in BREAK.
- busy=1 in every state except IDLE.
- FIFO is show-ahead: rd_data and flags reflect the head entry combinationally from storage; pop occurs on rd_valid & rd_ready.
- Push while full with no pop: entry dropped, overflow set. Push while full with a simultaneous pop: both succeed and level is unchanged.
- Pop while empty: ignored.
- clr_overflow in the same cycle as a new overflow: set wins.
- Pointers wrap modulo FIFO_DEPTH; level distinguishes full from empty.
- Latency: rd_valid rises 1 clock after the push cycle.

Decomposition:
- Package uart_rx_pkg holds the FSM state enum, the entry struct {frame_err, parity_err, data}, and the FIFO_PTR_W helper function.
- One natural sub-module, sync_fifo_showahead: parametrised width/depth, with push/pop/full/empty/level.

Test Plan (all with divisor=0, OVERSAMPLE=16, so one bit = 16 clocks):
- 8N1, send 0xA5 -> rd_data=0xA5, both flags 0, level 1 within 160 clocks of the falling edge; pop clears rd_valid.
- 7E2 (char_len=7, parity_en=1, parity_odd=0), send 0x55 with a wrong parity bit, then 0x2A correct -> entries {0x55, parity_err=1} and {0x2A, no errors}.
- Stop bit held low for 3 bit-times after 0x00 -> frame_err=1, exactly one entry pushed. No new entry until the line has been high and a fresh start bit is sent.
- 6-clock low glitch on an idle line -> busy pulses, FSM returns to IDLE, level stays 0.
- 17 characters sent with rd_ready=0 and FIFO_DEPTH=16 -> level=16, overflow=1, head is the 1st character. Then pop once while a character completes -> level stays 16. clr_overflow -> overflow 0.
- Assert reset mid-DATA -> all outputs return to reset values immediately; the next full frame 0x3C is received correctly.
